// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: exception request, writeback and arbitrated register-file bundle for exc_ctrl.
//   master: drives ex_req/ex_code/ex_pc and wb_we/wb_rd/wb_data; observes all outputs.
//   slave : exc_ctrl side; drives rf_*, fetch strobes, redirect address, busy, exc_count and sticky flags.
interface exc_ctrl_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   ex_req;
    logic [31:0]            ex_code;
    logic [31:0]            ex_pc;
    logic                   wb_we;
    logic [4:0]             wb_rd;
    logic [31:0]            wb_data;
    logic                   rf_we;
    logic [4:0]             rf_rd;
    logic [31:0]            rf_data;
    logic                   flush_fd;
    logic                   kill_x;
    logic                   pc_redirect_en;
    logic [31:0]            pc_redirect_addr;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] exc_count;
    logic                   overrun;
    logic                   conflict;

    modport master (
        output ex_req, ex_code, ex_pc, wb_we, wb_rd, wb_data,
        input  rf_we, rf_rd, rf_data, flush_fd, kill_x, pc_redirect_en,
               pc_redirect_addr, busy, exc_count, overrun, conflict
    );

    modport slave (
        input  ex_req, ex_code, ex_pc, wb_we, wb_rd, wb_data,
        output rf_we, rf_rd, rf_data, flush_fd, kill_x, pc_redirect_en,
               pc_redirect_addr, busy, exc_count, overrun, conflict
    );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: pipeline exception controller; squashes F/D, kills X, redirects fetch,
// then after draining older instructions writes the status code to STATUS_REG
// through the register-file write port shared with writeback.
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : exc_ctrl_if slave (X-stage request, writeback port, rf port, strobes, status)
module exc_ctrl #(
    parameter int DRAIN_CYCLES = 1,
    parameter int STATUS_REG   = 30,
    parameter int COUNT_WIDTH  = 16
) (
    input logic        clock,
    input logic        resetn,
    exc_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, WRITE} state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

    state_t                 state, state_d;
    logic [2:0]             drain_q, drain_d;
    logic [31:0]            status_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   overrun_q, conflict_q;
    logic                   valid, accept;

    assign valid  = bus.ex_req && (bus.ex_code != 32'd0);
    // Gating with resetn keeps the fetch strobes quiet while reset is held.
    assign accept = valid && (state == IDLE) && resetn;

    always_comb begin
        state_d = state;
        drain_d = drain_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = (DRAIN_CYCLES == 0) ? WRITE : DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            DRAIN: begin
                drain_d = drain_q - 3'd1;
                if (drain_q <= 3'd1) state_d = WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            drain_q    <= 3'd0;
            status_q   <= 32'd0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state   <= state_d;
            drain_q <= drain_d;
            if (accept) begin
                status_q <= bus.ex_code;
                if (~&count_q) count_q <= count_q + 1'b1;
            end
            if (valid && state != IDLE) overrun_q <= 1'b1;
            if (state == WRITE && bus.wb_we) conflict_q <= 1'b1;
        end
    end

    assign bus.flush_fd         = accept;
    assign bus.kill_x           = accept;
    assign bus.pc_redirect_en   = accept;
    assign bus.pc_redirect_addr = bus.ex_pc + 32'd1;
    assign bus.busy             = (state != IDLE);
    assign bus.exc_count        = count_q;
    assign bus.overrun          = overrun_q;
    assign bus.conflict         = conflict_q;
    // The status write owns the port in WRITE; any writeback in that cycle is dropped.
    assign bus.rf_we            = (state == WRITE) ? 1'b1 : bus.wb_we;
    assign bus.rf_rd            = (state == WRITE) ? 5'(STATUS_REG) : bus.wb_rd;
    assign bus.rf_data          = (state == WRITE) ? status_q : bus.wb_data;
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception controller for the 5-stage pipeline. Accepts an exception request from the execute stage (the status code produced by the exception decoder), squashes younger instructions, kills the excepting instruction, and redirects fetch. It then waits for older instructions to retire and writes the status code into `$rstatus` through the single register-file write port, which it shares with the writeback stage.

## Interface
Parameters:
- `DRAIN_CYCLES`, 1, cycles spent in DRAIN before the status write; legal 0..7.
- `STATUS_REG`, 30, register index written with the status code.
- `COUNT_WIDTH`, 16, width of the taken-exception counter.

Ports:
- `clock`  in  1  rising-edge clock; the only clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `ex_req`  in  1  exception request from the X stage, i.e. the decoder's enable.
- `ex_code`  in  32  status code from the X stage; meaningful when `ex_req`=1.
- `ex_pc`  in  32  PC of the instruction in X.
- `wb_we`  in  1  writeback-stage write enable.
- `wb_rd`  in  5  writeback destination register.
- `wb_data`  in  32  writeback data.
- `rf_we`  out  1  register-file write enable (arbitrated).
- `rf_rd`  out  5  register-file write index (arbitrated).
- `rf_data`  out  32  register-file write data (arbitrated).
- `flush_fd`  out  1  squash F and D at the next edge.
- `kill_x`  out  1  turn the X instruction into a bubble at the next edge.
- `pc_redirect_en`  out  1  load PC with `pc_redirect_addr` at the next edge.
- `pc_redirect_addr`  out  32  redirect target, `ex_pc`+1.
- `busy`  out  1  high in DRAIN or WRITE.
- `exc_count`  out  COUNT_WIDTH  number of accepted exceptions, saturating.
- `overrun`  out  1  sticky; set when a request is dropped because the block is busy.
- `conflict`  out  1  sticky; set when `wb_we`=1 during WRITE.

## Operation
- States are IDLE, DRAIN and WRITE. A 3-bit drain counter and a 32-bit `status_q` register back the state machine.
- Valid request: `ex_req`=1 and `ex_code`≠0. When `ex_req`=1 and `ex_code`=0, the block ignores the request entirely.
- Accept = valid request while in IDLE.
- In the accept cycle, combinationally from the inputs:
  - `flush_fd`=`kill_x`=`pc_redirect_en`=1.
  - `pc_redirect_addr`=`ex_pc`+1, modulo 2^32; 0xFFFFFFFF wraps to 0.
  - In every other cycle these three strobes are 0. `pc_redirect_addr` is then don't-care; the implementation drives `ex_pc`+1.
- At the accept edge:
  - `status_q`←`ex_code`.
  - `exc_count` increments, holding at all-ones.
  - The state moves to DRAIN with the counter loaded to `DRAIN_CYCLES`, or straight to WRITE if `DRAIN_CYCLES`=0.
- DRAIN: the counter decrements each cycle. When it reaches 1, the next state is WRITE. Old instructions in M and W retire normally.
- WRITE: lasts exactly 1 cycle.
  - `rf_we`=1, `rf_rd`=`STATUS_REG`, `rf_data`=`status_q`.
  - `wb_*` is ignored. If `wb_we`=1 in this cycle, `conflict` is set and the writeback write is lost.
  - Next state is IDLE.
- Port arbitration outside WRITE: `rf_*` = `wb_*` pass-through, combinational.
- Valid request in DRAIN or WRITE: no strobes, `status_q` is unchanged, and `overrun` is set.
- A request arriving in the cycle the block returns to IDLE (the cycle after WRITE) is accepted normally.
- A `setx` instruction writes `$rstatus` through the normal writeback path and is passed through unchanged.

## Timing
- Reset (`resetn`=0, asynchronous): state=IDLE; counter, `status_q`, `exc_count`, `overrun` and `conflict` all 0.
  - All strobes and `busy` are 0.
  - `rf_*` still follows `wb_*`, since IDLE is pass-through.
- Reset deassertion is applied at a clock edge; the first accept is possible in the first cycle after that.
- Reset asserted mid-DRAIN or mid-WRITE aborts the sequence; no status write occurs.
- Latency with accept in cycle T and default `DRAIN_CYCLES`=1:
  - DRAIN in T+1.
  - WRITE in T+2. This is the cycle the killed bubble occupies W.
  - IDLE in T+3.
- General case: WRITE occurs in cycle T+1+`DRAIN_CYCLES`.
- `busy` is high from T+1 through the WRITE cycle inclusive.
- `overrun` and `conflict` clear only on reset.

## Test plan
- Reset, then a single exception: `ex_req`=1, `ex_code`=1, `ex_pc`=0x40 at cycle T.
  - Cycle T: `flush_fd`=`kill_x`=`pc_redirect_en`=1 and `pc_redirect_addr`=0x41.
  - Cycle T+2: `rf_we`=1, `rf_rd`=30, `rf_data`=1.
  - `exc_count`=1 and `busy` high at T+1 and T+2.
- Pass-through during DRAIN: `wb_we`=1, `wb_rd`=5, `wb_data`=0xDEAD at T+1 → `rf_*` equals `wb_*` in that cycle and `conflict` stays 0.
- Overrun: `ex_code`=3 accepted at T, then `ex_code`=2 at T+1 → no strobes at T+1, status write at T+2 carries 3, `overrun`=1.
- Back-to-back requests:
  - `ex_code`=2 at T → write at T+2.
  - `ex_code`=3 at T+3 → accepted, write of 3 at T+5, `exc_count`=2, `overrun`=0.
- Boundaries:
  - `ex_req`=1 with `ex_code`=0 → no response at all.
  - `ex_pc`=0xFFFFFFFF → `pc_redirect_addr`=0.
  - `wb_we`=1 during WRITE → `conflict`=1 and `rf_rd`=30.
- Reset and parameters:
  - `resetn` low at T+1 → no write at T+2, all outputs 0, `rf_*` follows `wb_*`.
  - With `DRAIN_CYCLES`=0 → WRITE at T+1.
  - `exc_count` saturates at 0xFFFF.
